// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encodings and control FSM states.
package alu_pkg;

   localparam int unsigned AluCtrlWidth = 4;

   typedef enum logic [AluCtrlWidth-1:0] {
      AluAdd  = 4'b0000,
      AluSub  = 4'b0001,
      AluAnd  = 4'b0010,
      AluOr   = 4'b0011,
      AluXor  = 4'b0100,
      AluSlt  = 4'b0101,
      AluSltu = 4'b0110,
      AluSll  = 4'b0111,
      AluSrl  = 4'b1000,
      AluSra  = 4'b1001,
      AluMul  = 4'b1010,
      AluDivu = 4'b1011,
      AluRemu = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   function automatic logic is_divide_op(alu_op_e op);
      return (op == AluDivu) || (op == AluRemu);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the control unit and the sequential ALU.
interface alu_seq_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CTRL_WIDTH = 4
);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] alu_op1;
   logic [DATA_WIDTH-1:0] alu_op2;
   logic [CTRL_WIDTH-1:0] alu_ctrl;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] alu_out;
   logic                  eq;
   logic                  zero;

   modport master (
      output in_valid, alu_op1, alu_op2, alu_ctrl, out_ready,
      input  in_ready, out_valid, alu_out, eq, zero
   );

   modport slave (
      input  in_valid, alu_op1, alu_op2, alu_ctrl, out_ready,
      output in_ready, out_valid, alu_out, eq, zero
   );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add MUL (low half) and restoring DIVU/REMU, one step per cycle.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  alu_op_e               op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] res_o
);

   localparam int unsigned CntWidth = $clog2(DATA_WIDTH) + 1;

   // x: multiplicand / dividend shifting into quotient; y: multiplier / divisor;
   // acc: product accumulator / partial remainder.
   alu_op_e               op_q, op_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] x_q, x_d;
   logic [DATA_WIDTH-1:0] y_q, y_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH+1:0] trial;

   assign trial = {1'b0, acc_q, x_q[DATA_WIDTH-1]} - {2'b00, y_q};

   always_comb begin
      op_d  = op_q;
      cnt_d = cnt_q;
      x_d   = x_q;
      y_d   = y_q;
      acc_d = acc_q;
      if (start_i) begin
         op_d  = op_i;
         cnt_d = CntWidth'(DATA_WIDTH);
         x_d   = a_i;
         y_d   = b_i;
         acc_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CntWidth'(1);
         if (op_q == AluMul) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
         end else if (!trial[DATA_WIDTH+1]) begin
            acc_d = trial[DATA_WIDTH-1:0];
            x_d   = {x_q[DATA_WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {acc_q[DATA_WIDTH-2:0], x_q[DATA_WIDTH-1]};
            x_d   = {x_q[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   // Result is taken from the next-state values so the top can latch it on the final step.
   assign done_o = (cnt_q == CntWidth'(1));
   assign res_o  = (op_q == AluDivu) ? x_d : acc_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q  <= AluAdd;
         cnt_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         acc_q <= '0;
      end else begin
         op_q  <= op_d;
         cnt_q <= cnt_d;
         x_q   <= x_d;
         y_q   <= y_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: handshake FSM, single-cycle datapath ops and registered result/flags.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CTRL_WIDTH  = 4,
   parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input logic     clk,
   input logic     rst,
   alu_seq_if.slave bus
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d;
   logic                  eq_q, eq_d;
   logic                  zero_q, zero_d;

   alu_op_e               op;
   logic                  ctrl_ok;
   logic [DATA_WIDTH-1:0] a, b;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [DATA_WIDTH-1:0] single_res;
   logic                  iter_start;
   logic                  mdu_done;
   logic [DATA_WIDTH-1:0] mdu_res;

   assign a     = bus.alu_op1;
   assign b     = bus.alu_op2;
   assign shamt = b[SHAMT_WIDTH-1:0];
   assign op    = alu_op_e'(bus.alu_ctrl[AluCtrlWidth-1:0]);
   // Any set bit above the defined encoding field makes the op undefined.
   assign ctrl_ok = ((bus.alu_ctrl >> AluCtrlWidth) == '0);

   assign iter_start = ctrl_ok && ((op == AluMul) || (is_divide_op(op) && (b != '0)));

   always_comb begin
      single_res = '0;
      if (ctrl_ok) begin
         case (op)
            AluAdd:  single_res = a + b;
            AluSub:  single_res = a - b;
            AluAnd:  single_res = a & b;
            AluOr:   single_res = a | b;
            AluXor:  single_res = a ^ b;
            AluSlt:  single_res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            AluSltu: single_res = {{(DATA_WIDTH-1){1'b0}}, a < b};
            AluSll:  single_res = a << shamt;
            AluSrl:  single_res = a >> shamt;
            AluSra:  single_res = $signed(a) >>> shamt;
            // Only reached with a zero divisor; nonzero divisors go to the engine.
            AluDivu: single_res = '1;
            AluRemu: single_res = a;
            default: single_res = '0;
         endcase
      end
   end

   alu_muldiv_iter #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start_i(iter_start && bus.in_valid && (state_q == IDLE)),
      .op_i   (op),
      .a_i    (a),
      .b_i    (b),
      .done_o (mdu_done),
      .res_o  (mdu_res)
   );

   always_comb begin
      state_d   = state_q;
      alu_out_d = alu_out_q;
      eq_d      = eq_q;
      zero_d    = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               eq_d = (a == b);
               if (iter_start) begin
                  state_d = CALC;
               end else begin
                  alu_out_d = single_res;
                  zero_d    = (single_res == '0);
                  state_d   = DONE;
               end
            end
         end
         CALC: begin
            if (mdu_done) begin
               alu_out_d = mdu_res;
               zero_d    = (mdu_res == '0);
               state_d   = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         alu_out_q <= '0;
         eq_q      <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_out_q <= alu_out_d;
         eq_q      <= eq_d;
         zero_q    <= zero_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.alu_out   = alu_out_q;
   assign bus.eq        = eq_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: transaction-level model plus directed literal vectors.
module tb_alu_seq;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_seq_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(4)) bus ();

   alu_seq #(
      .DATA_WIDTH(DW),
      .CTRL_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] x,
                                             input logic [31:0] y);
      int unsigned sh;
      sh = y % 32;
      case (c)
         4'd0:    return x + y;
         4'd1:    return x - y;
         4'd2:    return x & y;
         4'd3:    return x | y;
         4'd4:    return x ^ y;
         4'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd6:    return (x < y) ? 32'd1 : 32'd0;
         4'd7:    return x << sh;
         4'd8:    return x >> sh;
         4'd9:    return 32'($signed(x) >>> sh);
         4'd10:   return x * y;
         4'd11:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
         4'd12:   return (y == 0) ? x : x % y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [3:0] c, input logic [31:0] y);
      if (c == 4'd10 || ((c == 4'd11 || c == 4'd12) && y != 0)) return DW + 1;
      return 1;
   endfunction

   // Transaction model: 0 idle, 1 computing, 2 result presented.
   int          m_phase = 0;
   int          m_wait  = 0;
   logic [31:0] m_res   = '0;
   logic        m_eq    = 1'b0;
   logic        m_zero  = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0;
         m_wait  <= 0;
      end else if (m_phase == 0) begin
         if (bus.in_valid) begin
            m_res   <= model_res(bus.alu_ctrl, bus.alu_op1, bus.alu_op2);
            m_eq    <= (bus.alu_op1 == bus.alu_op2);
            m_zero  <= (model_res(bus.alu_ctrl, bus.alu_op1, bus.alu_op2) == 0);
            m_wait  <= model_lat(bus.alu_ctrl, bus.alu_op2) - 1;
            m_phase <= (model_lat(bus.alu_ctrl, bus.alu_op2) == 1) ? 2 : 1;
         end
      end else if (m_phase == 1) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) m_phase <= 2;
      end else if (bus.out_ready) begin
         m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model in_ready", bus.in_ready, m_phase == 0);
         chk("model out_valid", bus.out_valid, m_phase == 2);
         if (m_phase == 2) begin
            chk("model alu_out", bus.alu_out, m_res);
            chk("model eq", bus.eq, m_eq);
            chk("model zero", bus.zero, m_zero);
         end
      end
   end

   task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic e, input logic z, input int lat);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = c;
      bus.alu_op1  = x;
      bus.alu_op2  = y;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!bus.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("op%0d latency", c), n, lat);
      chk($sformatf("op%0d alu_out", c), bus.alu_out, r);
      chk($sformatf("op%0d eq", c), bus.eq, e);
      chk($sformatf("op%0d zero", c), bus.zero, z);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.alu_ctrl  = '0;
      bus.alu_op1   = '0;
      bus.alu_op2   = '0;
      repeat (2) @(negedge clk);
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset alu_out", bus.alu_out, 0);
      chk("reset eq", bus.eq, 0);
      chk("reset zero", bus.zero, 0);
      rst = 1'b0;

      //     ctrl   op1            op2            result         eq    zero  lat
      run_op(4'd0,  32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1);
      run_op(4'd1,  32'd9,         32'd9,         32'd0,         1'b1, 1'b1, 1);
      run_op(4'd9,  32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1'b0, 1);
      run_op(4'd5,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0, 1);
      run_op(4'd6,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b1, 1);
      run_op(4'd7,  32'd1,         32'h24,        32'h10,        1'b0, 1'b0, 1);
      run_op(4'd8,  32'h8000_0000, 32'h1F,        32'd1,         1'b0, 1'b0, 1);
      run_op(4'd2,  32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0, 1);
      run_op(4'd3,  32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0, 1'b0, 1);
      run_op(4'd4,  32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0, 1'b0, 1);
      run_op(4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      run_op(4'd0,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b1, 1);
      run_op(4'd13, 32'd3,         32'd3,         32'd0,         1'b1, 1'b1, 1);
      run_op(4'd15, 32'd1,         32'd2,         32'd0,         1'b0, 1'b1, 1);
      run_op(4'd10, 32'hFFFF,      32'h1_0001,    32'hFFFF_FFFF, 1'b0, 1'b0, 33);
      run_op(4'd10, 32'h1234_5678, 32'd9,         32'hA3D7_0A38, 1'b0, 1'b0, 33);
      run_op(4'd10, 32'd0,         32'd5,         32'd0,         1'b0, 1'b1, 33);
      run_op(4'd11, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33);
      run_op(4'd12, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33);
      run_op(4'd11, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 1'b0, 1'b0, 33);
      run_op(4'd12, 32'hFFFF_FFFF, 32'h10,        32'hF,         1'b0, 1'b0, 33);
      run_op(4'd11, 32'd7,         32'd7,         32'd1,         1'b1, 1'b0, 33);
      run_op(4'd12, 32'd6,         32'd3,         32'd0,         1'b0, 1'b1, 33);
      run_op(4'd11, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      run_op(4'd12, 32'd5,         32'd0,         32'd5,         1'b0, 1'b0, 1);

      // Backpressure: result held while the consumer stalls, new requests ignored.
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.alu_ctrl  = 4'd0;
      bus.alu_op1   = 32'd3;
      bus.alu_op2   = 32'd3;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp first valid", bus.out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.alu_ctrl = 4'd1;
         bus.alu_op1  = 32'd9;
         bus.alu_op2  = 32'd1;
         chk("bp hold alu_out", bus.alu_out, 32'd6);
         chk("bp hold eq", bus.eq, 1);
         chk("bp hold in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.alu_ctrl  = 4'd4;
      bus.alu_op1   = 32'hF0;
      bus.alu_op2   = 32'hFF;
      @(posedge clk);
      #1;
      chk("bp release in_ready", bus.in_ready, 1);
      chk("bp release out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp next accepted", bus.in_ready, 0);
      @(negedge clk);
      chk("bp next valid", bus.out_valid, 1);
      chk("bp next alu_out", bus.alu_out, 32'h0F);

      // Reset in the middle of a multiply.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 4'd10;
      bus.alu_op1  = 32'hFFFF;
      bus.alu_op2  = 32'h1_0001;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("abort pre in_ready", bus.in_ready, 0);
      rst = 1'b1;
      #1;
      chk("abort out_valid", bus.out_valid, 0);
      chk("abort alu_out", bus.alu_out, 0);
      chk("abort in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      run_op(4'd0, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0, 1);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
